// File: rtl/fetch_pkg.sv
// ============================================================================
// Module      : fetch_pkg
// Description : Shared types and default sizes for the EnDMe fetch / PC
//               sequencer (state encoding, PC and branch-offset widths,
//               program start address).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package fetch_pkg;

  localparam int          PC_WIDTH_DEF     = 16;
  localparam int          OFFSET_WIDTH_DEF = 8;
  localparam logic [15:0] START_ADDR_DEF   = 16'h0000;

  // Program lifecycle states, explicitly encoded on two bits.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    HALT = 2'd2
  } fetch_state_t;

endpackage : fetch_pkg

`default_nettype wire

// File: rtl/mux_2.sv
// ============================================================================
// Module      : mux_2
// Description : Generic 2:1 multiplexer.
// Ports       : in0_i / in1_i - data inputs, sel_i - select (1 picks in1_i),
//               out_o - selected data.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module mux_2 #(
  parameter int data_width = 8
) (
  input  logic [data_width-1:0] in0_i,
  input  logic [data_width-1:0] in1_i,
  input  logic                  sel_i,
  output logic [data_width-1:0] out_o
);

  assign out_o = sel_i ? in1_i : in0_i;

endmodule : mux_2

`default_nettype wire

// File: rtl/fetch_pc_unit.sv
// ============================================================================
// Module      : fetch_pc_unit
// Description : Program-counter / instruction-fetch sequencer. Holds the
//               architectural PC, selects sequential / PC-relative branch /
//               absolute jump next PC, and runs the IDLE -> RUN -> HALT
//               program lifecycle.
// Ports       : clk, rst_n (async, active low)
//               start, stall, halt, jump_en, jump_addr, branch_en,
//               branch_offset                         - control from decode
//               pc, fetch_valid                       - fetch address/strobe
//               br_sel                                - next-PC mux select
//               done                                  - program halted
//               cycle_count (only with FETCH_CYCLE_COUNT_EN defined)
// Options     : FETCH_CYCLE_COUNT_EN - adds a saturating 32-bit count of
//               RUN cycles (stalls included), cleared on start.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module fetch_pc_unit
  import fetch_pkg::*;
#(
  parameter int                  PC_WIDTH     = PC_WIDTH_DEF,
  parameter int                  OFFSET_WIDTH = OFFSET_WIDTH_DEF,
  parameter logic [PC_WIDTH-1:0] START_ADDR   = PC_WIDTH'(START_ADDR_DEF)
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    start,
  input  logic                    stall,
  input  logic                    halt,
  input  logic                    jump_en,
  input  logic [PC_WIDTH-1:0]     jump_addr,
  input  logic                    branch_en,
  input  logic [OFFSET_WIDTH-1:0] branch_offset,
  output logic [PC_WIDTH-1:0]     pc,
  output logic                    fetch_valid,
  output logic                    br_sel,
  output logic                    done
`ifdef FETCH_CYCLE_COUNT_EN
  ,
  output logic [31:0]             cycle_count
`endif
);

  localparam logic [PC_WIDTH-1:0] c_pc_one = PC_WIDTH'(1);

  fetch_state_t          state_q, state_d;
  logic [PC_WIDTH-1:0]   pc_q, pc_d;
  logic                  done_q, done_d;

  logic [PC_WIDTH-1:0]   w_branch_target;
  logic [PC_WIDTH-1:0]   w_target;

  // Branch target: sign-extended offset added to the current PC; the adder
  // naturally wraps modulo 2^PC_WIDTH.
  assign w_branch_target = pc_q +
    {{(PC_WIDTH-OFFSET_WIDTH){branch_offset[OFFSET_WIDTH-1]}}, branch_offset};

  // Jump beats branch when both are requested, so jump_en alone selects.
  mux_2 #(
    .data_width (PC_WIDTH)
  ) u_target_mux (
    .in0_i (w_branch_target),
    .in1_i (jump_addr),
    .sel_i (jump_en),
    .out_o (w_target)
  );

  // --------------------------------------------------------------------------
  // State register
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      pc_q    <= START_ADDR;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      done_q  <= done_d;
    end
  end

  // --------------------------------------------------------------------------
  // Next-state logic
  // --------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    done_d  = done_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = RUN;
          pc_d    = START_ADDR;
        end
      end
      RUN: begin
        // A stall freezes everything; decode re-presents its request.
        if (!stall) begin
          if (halt) begin
            // PC stays on the halting instruction.
            state_d = HALT;
            done_d  = 1'b1;
          end else if (br_sel) begin
            pc_d = w_target;
          end else begin
            pc_d = pc_q + c_pc_one;
          end
        end
      end
      HALT: begin
        if (start) begin
          state_d = RUN;
          pc_d    = START_ADDR;
          done_d  = 1'b0;
        end
      end
      default: begin
        state_d = IDLE;
        pc_d    = START_ADDR;
        done_d  = 1'b0;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // Output logic
  // --------------------------------------------------------------------------
  always_comb begin
    fetch_valid = 1'b0;
    br_sel      = 1'b0;
    if (state_q == RUN && !stall) begin
      fetch_valid = 1'b1;
      br_sel      = !halt && (jump_en || branch_en);
    end
  end

  assign pc   = pc_q;
  assign done = done_q;

`ifdef FETCH_CYCLE_COUNT_EN
  logic [31:0] cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= 32'd0;
    end else if (start && state_q != RUN) begin
      cnt_q <= 32'd0;
    end else if (state_q == RUN && cnt_q != 32'hFFFF_FFFF) begin
      cnt_q <= cnt_q + 32'd1;
    end
  end

  assign cycle_count = cnt_q;
`endif

endmodule : fetch_pc_unit

`default_nettype wire

// File: tb/tb_fetch_pc_unit.sv
// ============================================================================
// Module      : tb_fetch_pc_unit
// Description : Self-checking bench for fetch_pc_unit. Directed scenarios
//               followed by random control traffic, all compared against a
//               behavioural model of the program lifecycle.
// Options     : FETCH_CYCLE_COUNT_EN - also connects and checks cycle_count.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_fetch_pc_unit;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic        stall;
  logic        halt;
  logic        jump_en;
  logic [15:0] jump_addr;
  logic        branch_en;
  logic [7:0]  branch_offset;
  logic [15:0] pc;
  logic        fetch_valid;
  logic        br_sel;
  logic        done;
`ifdef FETCH_CYCLE_COUNT_EN
  logic [31:0] cycle_count;
`endif

  int n_checks = 0;
  int n_pass   = 0;

  // Behavioural model: mode 0 = not started, 1 = running, 2 = halted.
  int     m_mode;
  int     m_pc;
  bit     m_done;
  longint m_cnt;

  fetch_pc_unit dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .start         (start),
    .stall         (stall),
    .halt          (halt),
    .jump_en       (jump_en),
    .jump_addr     (jump_addr),
    .branch_en     (branch_en),
    .branch_offset (branch_offset),
    .pc            (pc),
    .fetch_valid   (fetch_valid),
    .br_sel        (br_sel),
    .done          (done)
`ifdef FETCH_CYCLE_COUNT_EN
    ,
    .cycle_count   (cycle_count)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  task automatic model_reset();
    m_mode = 0;
    m_pc   = 0;
    m_done = 1'b0;
    m_cnt  = 0;
  endtask

  task automatic check_regs(input string tag);
    check({tag, ".pc"},   {16'h0, pc},        m_pc[31:0]);
    check({tag, ".done"}, {31'h0, done},      {31'h0, m_done});
`ifdef FETCH_CYCLE_COUNT_EN
    check({tag, ".cnt"},  cycle_count,        m_cnt[31:0]);
`endif
  endtask

  // Apply one cycle of inputs (called just after a falling edge), check the
  // outputs against the model, then advance model and DUT by one edge.
  task automatic step(input string tag, input bit st, input bit sl, input bit hl,
                      input bit je, input logic [15:0] ja, input bit be,
                      input logic [7:0] bo);
    bit exp_fv, exp_br;
    start = st; stall = sl; halt = hl;
    jump_en = je; jump_addr = ja; branch_en = be; branch_offset = bo;
    #1;
    exp_fv = (m_mode == 1) && !sl;
    exp_br = exp_fv && !hl && (je || be);
    check_regs(tag);
    check({tag, ".fv"}, {31'h0, fetch_valid}, {31'h0, exp_fv});
    check({tag, ".br"}, {31'h0, br_sel},      {31'h0, exp_br});
    if (m_mode == 1) begin
      if (m_cnt != 64'hFFFF_FFFF) m_cnt++;
      if (!sl) begin
        if (hl) begin
          m_mode = 2;
          m_done = 1'b1;
        end else if (je) m_pc = int'(ja);
        else if (be)     m_pc = (m_pc + int'($signed(bo))) & 32'hFFFF;
        else             m_pc = (m_pc + 1) & 32'hFFFF;
      end
    end else if (st) begin
      m_mode = 1;
      m_pc   = 0;
      m_done = 1'b0;
      m_cnt  = 0;
    end
    @(negedge clk);
  endtask

  task automatic idle_step(input string tag);
    step(tag, 0, 0, 0, 0, 16'h0, 0, 8'h0);
  endtask

  task automatic jump_to(input string tag, input logic [15:0] a);
    step(tag, 0, 0, 0, 1, a, 0, 8'h0);
  endtask

  // Asynchronous reset applied between clock edges; effect must be immediate.
  task automatic async_reset(input string tag);
    #2;
    rst_n = 1'b0;
    #1;
    model_reset();
    check_regs(tag);
    check({tag, ".fv"}, {31'h0, fetch_valid}, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n = 1'b0;
    start = 0; stall = 0; halt = 0; jump_en = 0; branch_en = 0;
    jump_addr = 16'h0; branch_offset = 8'h0;
    model_reset();
    repeat (2) @(negedge clk);
    #1;
    check_regs("rst");
    check("rst.fv", {31'h0, fetch_valid}, 32'h0);
    check("rst.br", {31'h0, br_sel}, 32'h0);
    rst_n = 1'b1;
    @(negedge clk);

    // Inputs other than start are ignored before the program starts.
    step("idle_ign", 0, 0, 1, 1, 16'h1234, 1, 8'h10);
    step("start", 1, 0, 0, 0, 16'h0, 0, 8'h0);
    for (int i = 0; i < 5; i++) idle_step("seq");          // pc now 0x0005
    step("br_back", 0, 0, 0, 0, 16'h0, 1, 8'hFE);          // -> 0x0003
    jump_to("j10", 16'h0010);
    step("br_fwd", 0, 0, 0, 0, 16'h0, 1, 8'h7F);           // -> 0x008F
    jump_to("j20", 16'h0020);
    step("jprio", 0, 0, 0, 1, 16'h0100, 1, 8'h04);         // -> 0x0100
    jump_to("jffff", 16'hFFFF);
    idle_step("wrap");                                      // -> 0x0000
    for (int i = 0; i < 3; i++) step("stall", 0, 1, 1, 1, 16'h5555, 1, 8'h22);
    idle_step("post_stall");
    step("start_in_run", 1, 0, 0, 0, 16'h0, 0, 8'h0);
    jump_to("j42", 16'h0042);
    step("halt", 0, 0, 1, 0, 16'h0, 0, 8'h0);
    for (int i = 0; i < 3; i++) step("halted", 0, 0, 0, 1, 16'hAAAA, 1, 8'h01);
    step("restart", 1, 0, 0, 0, 16'h0, 0, 8'h0);
    for (int i = 0; i < 3; i++) idle_step("run2");
    async_reset("arst");
    idle_step("after_arst");

    // Ten RUN cycles with two stalls, ending in halt; count then freezes.
    step("cnt_start", 1, 0, 0, 0, 16'h0, 0, 8'h0);
    for (int i = 0; i < 10; i++)
      step("cnt_run", 0, (i == 3 || i == 6), (i == 9), 0, 16'h0, 0, 8'h0);
    for (int i = 0; i < 4; i++) idle_step("cnt_frozen");

    // Random traffic.
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 99) == 0) begin
        async_reset("rnd_arst");
      end else begin
        step("rnd",
             $urandom_range(0, 99) < 8,
             $urandom_range(0, 99) < 20,
             $urandom_range(0, 99) < 4,
             $urandom_range(0, 99) < 15,
             16'($urandom),
             $urandom_range(0, 99) < 25,
             8'($urandom));
      end
    end
    idle_step("final");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  // Global watchdog so the run can never hang.
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule : tb_fetch_pc_unit

`default_nettype wire

// File: doc/fetch_pc_unit.md
Name: fetch_pc_unit

Overview:
- Program-counter / instruction-fetch sequencer for the EnDMe processor.
- Holds the architectural PC and produces the next PC from three sources: sequential (PC+1), PC-relative branch and absolute jump.
- Drives the instruction-memory address and the fetch-valid strobe consumed by decode.
- Its branch-vs-sequential choice is the select input of the downstream next-PC 2:1 mux.
- Controls the program lifecycle: start, run, halt/done.

Parameters:
- PC_WIDTH, 16, width of PC and jump address
- OFFSET_WIDTH, 8, width of signed branch offset
- START_ADDR, 16'h0000, PC loaded on reset and on every start

Ports:
- clk  input  1  system clock, rising edge
- rst_n  input  1  asynchronous active-low reset
- start  input  1  begin execution from START_ADDR (sampled in IDLE/HALT only)
- stall  input  1  freeze PC this cycle
- halt  input  1  decoded halt instruction
- jump_en  input  1  absolute jump request
- jump_addr  input  PC_WIDTH  absolute target
- branch_en  input  1  taken-branch request
- branch_offset  input  OFFSET_WIDTH  two's-complement offset relative to current PC
- pc  output  PC_WIDTH  current fetch address
- fetch_valid  output  1  pc is a valid fetch this cycle
- br_sel  output  1  next-PC mux select (1 = branch/jump target)
- done  output  1  program halted

Behaviour:
- Reset (async assert, sync-safe deassert): state=IDLE, pc=START_ADDR, done=0; fetch_valid=0, br_sel=0. Reset mid-RUN aborts immediately; no pending update is retained.
- States: IDLE, RUN, HALT. Registered state, 1-cycle transitions.
- IDLE: start=1 -> RUN at next edge, pc=START_ADDR. Other inputs ignored.
- RUN:
  - fetch_valid = (state==RUN) && !stall, combinational.
  - Per edge, priority: stall > halt > jump_en > branch_en > sequential.
  - stall=1: pc and state hold; halt/jump/branch ignored (decode re-presents them).
  - halt=1: -> HALT, pc holds at the halting instruction.
  - jump_en=1: pc <= jump_addr.
  - branch_en=1: pc <= pc + sign_extend(branch_offset), modulo 2^PC_WIDTH.
  - Else: pc <= pc+1; 0xFFFF wraps to 0x0000.
  - br_sel = 1 when jump_en or branch_en wins the priority this cycle, else 0; 0 while stalled.
  - start ignored in RUN.
- HALT:
  - done=1 registered, asserted on the first HALT cycle; fetch_valid=0, br_sel=0, pc holds.
  - start=1 -> RUN with pc=START_ADDR; done clears on that same edge.
- Latency: a control input in cycle N changes pc at edge N+1; new pc is fetch-valid in cycle N+1.
- Simultaneous jump_en and branch_en: jump wins; no error signalled.

Optional Feature:
- Macro FETCH_CYCLE_COUNT_EN.
- Defined:
  - Adds output cycle_count [31:0].
  - Reset to 0; cleared on the start edge.
  - Increments every RUN cycle including stalls; saturates at 32'hFFFF_FFFF.
  - Frozen in HALT.
- Undefined: port and counter absent; all other behaviour identical.

Decomposition:
- Package fetch_pkg:
  - fetch_state_t enum {IDLE, RUN, HALT}
  - PC_WIDTH_DEF=16, OFFSET_WIDTH_DEF=8
  - START_ADDR_DEF
- Sub-modules:
  - Target selection (jump vs branch target) instantiates the existing mux_2 with data_width=PC_WIDTH.
  - No other sub-module.
  - Adder and sign extension stay inline.

Test Plan:
- Reset/start: rst_n low then high, start pulse -> pc=0x0000, fetch_valid=1 next cycle, then pc 0x0001, 0x0002, 0x0003 on successive edges; done=0.
- Branch: at pc=0x0005, branch_en=1, offset=8'hFE -> pc=0x0003, br_sel=1 that cycle; offset=8'h7F at 0x0010 -> 0x008F.
- Jump priority: jump_en=1 (addr 0x0100) with branch_en=1 (offset 0x04) at pc=0x0020 -> pc=0x0100.
- Wrap and stall: pc=0xFFFF sequential -> 0x0000; stall=1 for 3 cycles with halt=1 -> pc holds, fetch_valid=0, state stays RUN.
- Halt/restart: halt=1 at pc=0x0042 -> done=1, pc=0x0042, fetch_valid=0; start -> pc=0x0000, done=0. Async rst_n low mid-RUN -> pc=0x0000, state IDLE, done=0 immediately.
- FETCH_CYCLE_COUNT_EN: start, run 10 cycles including 2 stalls, halt -> cycle_count=10 and stays frozen in HALT.
